ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/pong_pkg.sv | 30 +++
 rtl/ps2_rx.sv | 127 ++++++++++++
 rtl/ps2_key_decoder.sv | 98 +++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared PS/2 scan codes and frame-receiver state encoding.
// Revision : 1.0
// ============================================================================
package pong_pkg;

    localparam logic [7:0] c_SC_EXT  = 8'hE0;
    localparam logic [7:0] c_SC_BRK  = 8'hF0;
    localparam logic [7:0] c_KEY_P1P = 8'h1D;
    localparam logic [7:0] c_KEY_P1M = 8'h1B;
    localparam logic [7:0] c_KEY_P2P = 8'h75;  // extended (E0-prefixed)
    localparam logic [7:0] c_KEY_P2M = 8'h72;  // extended (E0-prefixed)
    localparam logic [7:0] c_KEY_SRV = 8'h29;
    localparam logic [7:0] c_KEY_STA = 8'h5A;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t c_ST_IDLE   = 2'd0;
    localparam rx_state_t c_ST_DATA   = 2'd1;
    localparam rx_state_t c_ST_PARITY = 2'd2;
    localparam rx_state_t c_ST_STOP   = 2'd3;

    // Odd parity holds when the data bits plus the parity bit contain an odd count of ones.
    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 frame receiver: synchronizer, clock filter, frame FSM.
// Revision : 1.0
// ============================================================================
module ps2_rx
    import pong_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int c_FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_FW-1:0] c_FILT_MAX = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_MAX   = c_TW'(TIMEOUT_CYC - 1);

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt_clk;
    logic [c_FW-1:0] r_filt_cnt;
    rx_state_t       r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [c_TW-1:0] r_to_cnt;
    logic            r_byte_valid, r_frame_err;
    logic [7:0]      r_byte_data;
    logic            w_flip, w_sample;

    assign w_flip   = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == c_FILT_MAX);
    assign w_sample = w_flip && r_filt_clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            // The count only grows while the synchronized level disagrees with the filtered one.
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (w_flip) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte_data  <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == c_ST_IDLE || w_sample) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TW'(1);
            end

            if (w_sample) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= c_ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_PARITY;
                        end
                    end
                    c_ST_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= c_ST_STOP;
                    end
                    default: begin
                        if (r_dat_s2 && odd_parity_ok({r_par, r_shift})) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end else if (r_state != c_ST_IDLE && r_to_cnt == c_TO_MAX) begin
                r_state     <= c_ST_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : Decodes PS/2 make/break codes into held-key levels for pong.
// Revision : 1.0
// ============================================================================
module ps2_key_decoder
    import pong_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1p,
    output logic       p1m,
    output logic       p2p,
    output logic       p2m,
    output logic       serve,
    output logic       start,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    logic       w_byte_valid, w_frame_err;
    logic [7:0] w_byte;
    logic       r_ext, r_brk;
    logic       r_p1p, r_p1m, r_p2p, r_p2m, r_serve, r_start;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte),
        .frame_err  (w_frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_p1p   <= 1'b0;
            r_p1m   <= 1'b0;
            r_p2p   <= 1'b0;
            r_p2m   <= 1'b0;
            r_serve <= 1'b0;
            r_start <= 1'b0;
        end else if (w_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (w_byte_valid) begin
            if (w_byte == c_SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte == c_SC_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                // A key only matches when its ext prefix state is right.
                if (!r_ext) begin
                    case (w_byte)
                        c_KEY_P1P: r_p1p   <= ~r_brk;
                        c_KEY_P1M: r_p1m   <= ~r_brk;
                        c_KEY_SRV: r_serve <= ~r_brk;
                        c_KEY_STA: r_start <= ~r_brk;
                        default: ;
                    endcase
                end else begin
                    case (w_byte)
                        c_KEY_P2P: r_p2p <= ~r_brk;
                        c_KEY_P2M: r_p2m <= ~r_brk;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign p1p        = r_p1p;
    assign p1m        = r_p1m;
    assign p2p        = r_p2p;
    assign p2m        = r_p2m;
    assign serve      = r_serve;
    assign start      = r_start;
    assign byte_valid = w_byte_valid;
    assign byte_data  = w_byte;
    assign frame_err  = w_frame_err;

endmodule
`default_nettype wire
